// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// the FSM state encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is never entered on purpose; the controller recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell: purely combinational, assembled from XOR/AND/OR gates.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic prop;
  logic gen;
  logic prop_carry;

  // Carry out is either generated by a&b or propagated from ci when a^b.
  assign prop       = a ^ b;
  assign gen        = a & b;
  assign prop_carry = prop & ci;
  assign s          = prop ^ ci;
  assign co         = gen | prop_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: steps one shared full-adder cell through
// WIDTH cycles, LSB first, and latches sum, carry-out and signed overflow at the end.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic            carry;
  logic            c_msb_in;
  logic [CW-1:0]   cnt;

  logic fa_s;
  logic fa_co;

  full_adder_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Subtraction is folded into the load: B is inverted and the carry-in flipped,
  // so the RUN loop only ever adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= sub ? ~op_b : op_b;
            carry <= cin ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_MSB_IN) begin
            c_msb_in <= fa_co;
          end
          if (cnt == CNT_LAST) begin
            sum      <= {fa_s, res_sh[WIDTH-1:1]};
            cout     <= fa_co;
            overflow <= c_msb_in ^ fa_co;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases with literal results
// plus randomized operations compared every cycle against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic: plain wide add/subtract, signed overflow from operand/result signs.
  function automatic void refCompute(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci, input logic s,
                                     output logic [W-1:0] r, output logic co, output logic ov);
    logic [W:0] full;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      r    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      r    = full[W-1:0];
      co   = ~full[W];
      ov   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
  endfunction

  // Behavioural model: an accepted request completes W cycles later with a one-cycle done.
  int           run_left = 0;
  bit           chk_en   = 0;
  logic         m_busy, m_done, m_cout, m_ov;
  logic [W-1:0] m_sum;
  logic [W-1:0] p_sum;
  logic         p_cout, p_ov;

  always @(posedge clk) begin
    if (rst) begin
      run_left = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_sum    = '0;
      m_cout   = 1'b0;
      m_ov     = 1'b0;
      chk_en   = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ov   = p_ov;
      end
    end else if (start) begin
      refCompute(op_a, op_b, cin, sub, p_sum, p_cout, p_ov);
      run_left = W;
      m_busy   = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_busy", 32'(busy), 32'(m_busy));
      checkOutput("cyc_done", 32'(done), 32'(m_done));
      checkOutput("cyc_sum", 32'(sum), 32'(m_sum));
      checkOutput("cyc_cout", 32'(cout), 32'(m_cout));
      checkOutput("cyc_overflow", 32'(overflow), 32'(m_ov));
    end
  end

  // Launches one operation and returns the cycle (accept = 0) in which done is seen.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input logic s,
                               input bit noise, input bit scramble, output int lat);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = ci;
    sub   = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      if (scramble) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
        cin  = 1'($urandom);
        sub  = 1'($urandom);
      end
      if (noise) start = (lat == 3);
      @(negedge clk);
      lat++;
    end
    if (noise && done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int n;
    int pulses;
    int first_done;
    int second_done;

    rst   = 1'b1;
    start = 1'b1;
    op_a  = 8'hAA;
    op_b  = 8'h55;
    cin   = 1'b1;
    sub   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_sum", 32'(sum), 32'h0);
    checkOutput("rst_cout", 32'(cout), 32'h0);
    checkOutput("rst_ovf", 32'(overflow), 32'h0);
    start = 1'b0;
    rst   = 1'b0;

    applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checkOutput("add_latency", 32'(lat), 32'd9);
    checkOutput("add_sum", 32'(sum), 32'h7F);
    checkOutput("add_cout", 32'(cout), 32'h0);
    checkOutput("add_ovf", 32'(overflow), 32'h0);

    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    checkOutput("cin_sum", 32'(sum), 32'h00);
    checkOutput("cin_cout", 32'(cout), 32'h1);
    checkOutput("cin_ovf", 32'(overflow), 32'h0);

    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checkOutput("ovf_sum", 32'(sum), 32'h80);
    checkOutput("ovf_cout", 32'(cout), 32'h0);
    checkOutput("ovf_ovf", 32'(overflow), 32'h1);

    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    checkOutput("sub_sum", 32'(sum), 32'hF0);
    checkOutput("sub_cout", 32'(cout), 32'h0);
    checkOutput("sub_ovf", 32'(overflow), 32'h0);

    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, lat);
    checkOutput("subovf_latency", 32'(lat), 32'd9);
    checkOutput("subovf_sum", 32'(sum), 32'h7F);
    checkOutput("subovf_cout", 32'(cout), 32'h1);
    checkOutput("subovf_ovf", 32'(overflow), 32'h1);

    // Back-to-back: with start held high the second done lands W+2 cycles after the first.
    @(negedge clk);
    op_a  = 8'h12;
    op_b  = 8'h34;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    first_done  = -1;
    second_done = -1;
    for (int t = 0; t < 60 && second_done < 0; t++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = t;
        else second_done = t;
      end
    end
    start = 1'b0;
    checkOutput("hold_gap", 32'(second_done - first_done), 32'(W + 2));
    checkOutput("hold_sum", 32'(sum), 32'h46);

    // Reset during RUN cycle 4.
    @(negedge clk);
    op_a  = 8'h99;
    op_b  = 8'h66;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_sum", 32'(sum), 32'h0);
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 32'(pulses), 32'h0);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checkOutput("midrst_latency", 32'(lat), 32'd9);
    checkOutput("midrst_sum2", 32'(sum), 32'h02);

    // Randomized operations, checked cycle by cycle against the model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), lat);
      checkOutput("rand_latency", 32'(lat), 32'd9);
      n = $urandom_range(0, 3);
      repeat (n) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
